// File: rtl/prime_seq_ctrl.sv
// Nth-prime sequencer: owns candidate/divisor counters, issues trial divisions.
// Optional ODD_SKIP_EN: after 2, only odd candidates and odd divisors are tried.
module prime_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int N_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [N_W-1:0]   n_i,
    output logic             mod_req_o,
    output logic [WIDTH-1:0] mod_dividend_o,
    output logic [WIDTH-1:0] mod_divisor_o,
    input  logic             mod_ack_i,
    input  logic [WIDTH-1:0] mod_rem_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [WIDTH-1:0] prime_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_CHECK,
        S_REQ,
        S_EVAL,
        S_NEXT,
        S_DONE
    } state_t;

    localparam logic [WIDTH-1:0] C_MAX = '1;

`ifdef ODD_SKIP_EN
    localparam logic [WIDTH-1:0] D_START = WIDTH'(3);
    localparam logic [WIDTH-1:0] D_STEP  = WIDTH'(2);
    localparam logic [WIDTH-1:0] C_LAST  = C_MAX - WIDTH'(1);
`else
    localparam logic [WIDTH-1:0] D_START = WIDTH'(2);
    localparam logic [WIDTH-1:0] D_STEP  = WIDTH'(1);
    localparam logic [WIDTH-1:0] C_LAST  = C_MAX;
`endif

    state_t             r_state;
    logic [N_W-1:0]     r_n;
    logic [N_W-1:0]     r_cnt;
    logic [WIDTH-1:0]   r_cand;
    logic [WIDTH-1:0]   r_d;
    logic [WIDTH-1:0]   r_rem;
    logic               r_is_prime;
    logic               r_req;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
    logic [WIDTH-1:0]   r_prime;

    logic [2*WIDTH-1:0] w_d_ext;
    logic [2*WIDTH-1:0] w_cand_ext;
    logic [2*WIDTH-1:0] w_sq;
    logic               w_sq_gt;
    logic [N_W-1:0]     w_cnt_inc;
    logic [WIDTH-1:0]   w_cand_nxt;

    // Full-width square keeps the d*d > cand test free of overflow
    assign w_d_ext    = {{WIDTH{1'b0}}, r_d};
    assign w_cand_ext = {{WIDTH{1'b0}}, r_cand};
    assign w_sq       = w_d_ext * w_d_ext;
    assign w_sq_gt    = (w_sq > w_cand_ext);
    assign w_cnt_inc  = r_cnt + N_W'(1);

`ifdef ODD_SKIP_EN
    assign w_cand_nxt = (r_cand == WIDTH'(2)) ? WIDTH'(3)
                                              : r_cand + WIDTH'(2);
`else
    assign w_cand_nxt = r_cand + WIDTH'(1);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_n        <= '0;
            r_cnt      <= '0;
            r_cand     <= '0;
            r_d        <= '0;
            r_rem      <= '0;
            r_is_prime <= 1'b0;
            r_req      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_prime    <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_n     <= n_i;
                        r_prime <= '0;
                        if (n_i == '0) begin
                            r_err   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_err   <= 1'b0;
                            r_busy  <= 1'b1;
                            r_state <= S_INIT;
                        end
                    end
                end
                S_INIT: begin
                    r_cand  <= WIDTH'(2);
                    r_cnt   <= '0;
                    r_d     <= D_START;
                    r_state <= S_CHECK;
                end
                S_CHECK: begin
                    if (w_sq_gt) begin
                        if (w_cnt_inc == r_n) begin
                            r_prime <= r_cand;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_is_prime <= 1'b1;
                            r_state    <= S_NEXT;
                        end
                    end else begin
                        r_req   <= 1'b1;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mod_ack_i) begin
                        r_rem   <= mod_rem_i;
                        r_req   <= 1'b0;
                        r_state <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    if (r_rem == '0) begin
                        r_is_prime <= 1'b0;
                        r_state    <= S_NEXT;
                    end else begin
                        r_d     <= r_d + D_STEP;
                        r_state <= S_CHECK;
                    end
                end
                S_NEXT: begin
                    if (r_is_prime) begin
                        r_cnt <= w_cnt_inc;
                    end
                    if (r_cand >= C_LAST) begin
                        r_err   <= 1'b1;
                        r_prime <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cand  <= w_cand_nxt;
                        r_d     <= D_START;
                        r_state <= S_CHECK;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mod_req_o      = r_req;
    assign mod_dividend_o = r_cand;
    assign mod_divisor_o  = r_d;
    assign busy_o         = r_busy;
    assign done_o         = r_done;
    assign err_o          = r_err;
    assign prime_o        = r_prime;

endmodule

// File: tb/tb_prime_seq_ctrl.sv
// Scoreboard bench for prime_seq_ctrl with a randomised-latency modulo unit.
// Expected results come from a plain trial-division model of the Nth prime.
module tb_prime_seq_ctrl;

    localparam int WIDTH = 8;
    localparam int N_W   = 4;
`ifdef ODD_SKIP_EN
    localparam bit ODD = 1'b1;
`else
    localparam bit ODD = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start_i;
    logic [N_W-1:0]   n_i;
    logic             mod_req_o;
    logic [WIDTH-1:0] mod_dividend_o;
    logic [WIDTH-1:0] mod_divisor_o;
    logic             mod_ack_i;
    logic [WIDTH-1:0] mod_rem_i;
    logic             busy_o;
    logic             done_o;
    logic             err_o;
    logic [WIDTH-1:0] prime_o;

    logic             st4;
    logic [3:0]       n4;
    logic             req4;
    logic [3:0]       dvd4;
    logic [3:0]       dvs4;
    logic             ack4;
    logic [3:0]       rem4;
    logic             busy4;
    logic             done4;
    logic             err4;
    logic [3:0]       prime4;

    always #5 clk = ~clk;

    prime_seq_ctrl #(.WIDTH(WIDTH), .N_W(N_W)) u_dut (
        .clk(clk), .rst(rst), .start_i(start_i), .n_i(n_i),
        .mod_req_o(mod_req_o), .mod_dividend_o(mod_dividend_o),
        .mod_divisor_o(mod_divisor_o), .mod_ack_i(mod_ack_i),
        .mod_rem_i(mod_rem_i), .busy_o(busy_o), .done_o(done_o),
        .err_o(err_o), .prime_o(prime_o)
    );

    prime_seq_ctrl #(.WIDTH(4), .N_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .start_i(st4), .n_i(n4),
        .mod_req_o(req4), .mod_dividend_o(dvd4),
        .mod_divisor_o(dvs4), .mod_ack_i(ack4),
        .mod_rem_i(rem4), .busy_o(busy4), .done_o(done4),
        .err_o(err4), .prime_o(prime4)
    );

    typedef struct {
        bit err;
        int prime;
        int nreq;
        int base;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;
    int   req_cnt = 0;
    int   last_prime = 0;
    int   last_err = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t",
                     name, act, req, $time);
        end
    endtask

    // Nth prime by trial division; also counts the remainder tests needed
    function automatic void model(input int n, input int w, output bit err,
                                  output int prime, output int nreq);
        int c;
        int cnt;
        int lim;
        bit isp;
        err = 1'b0;
        prime = 0;
        nreq = 0;
        if (n == 0) begin
            err = 1'b1;
            return;
        end
        lim = (1 << w) - 1;
        cnt = 0;
        c = 2;
        forever begin
            isp = 1'b1;
            for (int d = (ODD ? 3 : 2); d * d <= c; d += (ODD ? 2 : 1)) begin
                nreq++;
                if (c % d == 0) begin
                    isp = 1'b0;
                    break;
                end
            end
            if (isp) begin
                cnt++;
                if (cnt == n) begin
                    prime = c;
                    return;
                end
            end
            if (c >= lim - (ODD ? 1 : 0)) begin
                err = 1'b1;
                return;
            end
            if (ODD) c = (c == 2) ? 3 : c + 2;
            else     c = c + 1;
        end
    endfunction

    task automatic wait_idle();
        int k = 0;
        while ((busy_o || done_o || sb_q.size() != 0) && k < 5000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 5000) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout pending=%0d", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic do_start(input int n);
        exp_t e;
        bit   er;
        int   p;
        int   q;
        wait_idle();
        repeat ($urandom_range(1, 3)) @(negedge clk);
        check("hold_prime", 32'(prime_o), last_prime);
        check("hold_err", 32'(err_o), last_err);
        model(n, WIDTH, er, p, q);
        e.err = er;
        e.prime = p;
        e.nreq = q;
        e.base = req_cnt;
        start_i = 1'b1;
        n_i = N_W'(n);
        sb_q.push_back(e);
        @(negedge clk);
        start_i = 1'b0;
        if (n == 0) check("zero_done_next", 32'(done_o), 1);
    endtask

    // Modulo unit: ack 1..3 cycles after req, plus stray acks while idle
    initial begin
        logic [WIDTH-1:0] dvd;
        logic [WIDTH-1:0] dvs;
        int dly;
        bit gone;
        mod_ack_i = 1'b0;
        mod_rem_i = '0;
        forever begin
            @(negedge clk);
            mod_ack_i = 1'b0;
            if (mod_req_o === 1'b1) begin
                dvd = mod_dividend_o;
                dvs = mod_divisor_o;
                check("divisor_nonzero", 32'(dvs != 0), 1);
                dly = $urandom_range(0, 2);
                gone = 1'b0;
                for (int i = 0; i < dly; i++) begin
                    @(negedge clk);
                    if (mod_req_o !== 1'b1) begin
                        gone = 1'b1;
                        break;
                    end
                    check("operands_stable",
                          32'({mod_dividend_o, mod_divisor_o}), 32'({dvd, dvs}));
                end
                if (!gone) begin
                    mod_ack_i = 1'b1;
                    mod_rem_i = dvd % dvs;
                    req_cnt++;
                end
            end else if ($urandom_range(0, 5) == 0) begin
                mod_ack_i = 1'b1;
                mod_rem_i = WIDTH'($urandom);
            end
        end
    end

    initial begin
        ack4 = 1'b0;
        rem4 = '0;
        forever begin
            @(negedge clk);
            ack4 = req4 && !ack4;
            rem4 = (dvs4 != 0) ? dvd4 % dvs4 : 4'd0;
        end
    end

    // Monitor: every done pulse must match the oldest outstanding search
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done_o === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=1 required=0");
                end else begin
                    e = sb_q.pop_front();
                    check("prime", 32'(prime_o), e.prime);
                    check("err", 32'(err_o), 32'(e.err));
                    check("nreq", req_cnt - e.base, e.nreq);
                    check("busy_at_done", 32'(busy_o), 0);
                    last_prime = e.prime;
                    last_err = 32'(e.err);
                end
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int  k;
        bit  er;
        int  p;
        int  q;
        start_i = 1'b0;
        n_i = '0;
        st4 = 1'b0;
        n4 = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_req", 32'(mod_req_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_done", 32'(done_o), 0);
        check("rst_err", 32'(err_o), 0);
        check("rst_prime", 32'(prime_o), 0);
        check("rst_operands", 32'({mod_dividend_o, mod_divisor_o}), 0);
        check("rst_busy4", 32'(busy4), 0);
        rst = 1'b0;
        @(negedge clk);

        do_start(1);
        do_start(3);
        do_start(15);
        do_start(5);
        do_start(0);

        do_start(10);
        repeat (8) @(negedge clk);
        check("busy_mid", 32'(busy_o), 1);
        start_i = 1'b1;
        n_i = N_W'(3);
        @(negedge clk);
        start_i = 1'b0;

        do_start(12);
        k = 0;
        while (mod_req_o !== 1'b1 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("req_seen", 32'(mod_req_o), 1);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_req", 32'(mod_req_o), 0);
        check("rst_mid_busy", 32'(busy_o), 0);
        check("rst_mid_done", 32'(done_o), 0);
        sb_q.delete();
        last_prime = 0;
        last_err = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        do_start(2);

        for (int i = 0; i < 25; i++) begin
            do_start($urandom_range(0, 15));
        end
        wait_idle();

        for (int n = 1; n <= 7; n++) begin
            model(n, 4, er, p, q);
            @(negedge clk);
            st4 = 1'b1;
            n4 = 4'(n);
            @(negedge clk);
            st4 = 1'b0;
            k = 0;
            while (done4 !== 1'b1 && k < 2000) begin
                @(negedge clk);
                k++;
            end
            check("w4_done", 32'(done4), 1);
            check("w4_prime", 32'(prime4), p);
            check("w4_err", 32'(err4), 32'(er));
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
